// File: rtl/req_credit_tx.sv
// req_credit_tx: request-channel transmitter for the req_val/req_data/req_credit
// channel. Producer requests are buffered in a small FIFO and issued as
// single-beat transfers, one per cycle at most, whenever both a queued entry
// and a credit are available. A drain handshake lets a sequencer quiesce the
// channel: no new requests are accepted, the FIFO empties, and drained rises
// once every outstanding credit has come back.
module req_credit_tx #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MAX_CREDITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     req_val,
  output logic [DATA_W-1:0]        req_data,
  input  logic                     req_credit,
  input  logic                     drain_req,
  output logic                     drained,
  output logic [3:0]               credit_cnt,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     err_credit_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0]       MAX_CRED = 4'(MAX_CREDITS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DRAINED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          credit_q, credit_d;
  logic                req_val_q, req_val_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic                err_q, err_d;
  logic                drained_q, drained_d;

  logic                rdy;
  logic                push;
  logic                send;

  // Handshake and issue decisions; ready depends on occupancy only, so a pop
  // in the same cycle never opens a slot early.
  always_comb begin
    rdy  = (state_q == ST_RUN) && (cnt_q < FULL_CNT);
    push = in_val && rdy;
    send = (cnt_q != '0) && (credit_q != '0);
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (send) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, send})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Output beat register: the head entry is launched the cycle after send.
  always_comb begin
    req_val_d  = send;
    req_data_d = req_data_q;
    if (send) begin
      req_data_d = mem_q[rd_ptr_q];
    end
  end

  // Credit counter: a return in the same cycle as a send cancels out; a
  // return with no send while already full is dropped and flagged.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (send && !req_credit) begin
      credit_d = credit_q - 4'd1;
    end else if (!send && req_credit) begin
      if (credit_q == MAX_CRED) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + 4'd1;
      end
    end
  end

  // Control FSM; drain completion also requires no beat in flight this cycle,
  // since a send paired with a credit return leaves the count at MAX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (drain_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!drain_req) begin
          state_d = ST_RUN;
        end else if ((cnt_q == '0) && (credit_q == MAX_CRED) && !req_val_q) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        if (!drain_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    drained_d = (state_d == ST_DRAINED);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      credit_q   <= MAX_CRED;
      req_val_q  <= 1'b0;
      req_data_q <= '0;
      err_q      <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      credit_q   <= credit_d;
      req_val_q  <= req_val_d;
      req_data_q <= req_data_d;
      err_q      <= err_d;
      drained_q  <= drained_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_rdy         = rdy;
  assign req_val        = req_val_q;
  assign req_data       = req_data_q;
  assign drained        = drained_q;
  assign credit_cnt     = credit_q;
  assign fifo_cnt       = cnt_q;
  assign err_credit_ovf = err_q;

endmodule

// File: tb/tb_req_credit_tx.sv
// Bench for req_credit_tx: queue/integer reference model updated per clock,
// compared against every DUT output on each falling edge, plus directed
// literal checks at the key points of each scenario.
module tb_req_credit_tx;

  localparam int DEPTH = 4;
  localparam int MAXC  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_val;
  logic        in_rdy;
  logic [63:0] in_data;
  logic        req_val;
  logic [63:0] req_data;
  logic        req_credit;
  logic        drain_req;
  logic        drained;
  logic [3:0]  credit_cnt;
  logic [2:0]  fifo_cnt;
  logic        err_credit_ovf;

  int checks = 0;
  int errors = 0;

  req_credit_tx #(
    .DATA_W      (64),
    .DEPTH       (DEPTH),
    .MAX_CREDITS (MAXC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_val         (in_val),
    .in_rdy         (in_rdy),
    .in_data        (in_data),
    .req_val        (req_val),
    .req_data       (req_data),
    .req_credit     (req_credit),
    .drain_req      (drain_req),
    .drained        (drained),
    .credit_cnt     (credit_cnt),
    .fifo_cnt       (fifo_cnt),
    .err_credit_ovf (err_credit_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: mode 0 = startup cycle, 1 = accepting, 2 = draining,
  // 3 = quiesced.
  logic [63:0] mq[$];
  int          m_cred = MAXC;
  bit          m_ovf  = 1'b0;
  bit          m_val  = 1'b0;
  logic [63:0] m_data = '0;
  int          m_mode = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_cred = MAXC;
      m_ovf  = 1'b0;
      m_val  = 1'b0;
      m_data = '0;
      m_mode = 0;
    end else begin
      bit acc;
      bit snd;
      int n;
      n   = mq.size();
      acc = (m_mode == 1) && (n < DEPTH) && in_val;
      snd = (n > 0) && (m_cred > 0);
      case (m_mode)
        0: m_mode = 1;
        1: if (drain_req) m_mode = 2;
        2: if (!drain_req) m_mode = 1;
           else if (n == 0 && m_cred == MAXC && !m_val) m_mode = 3;
        3: if (!drain_req) m_mode = 1;
        default: m_mode = 0;
      endcase
      m_val = snd;
      if (snd) m_data = mq.pop_front();
      if (acc) mq.push_back(in_data);
      if (snd && !req_credit) m_cred = m_cred - 1;
      else if (!snd && req_credit) begin
        if (m_cred == MAXC) m_ovf = 1'b1;
        else m_cred = m_cred + 1;
      end
    end
  end

  logic [63:0] beat_log[$];
  int          beat_cyc[$];
  int          cyc = 0;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    cyc++;
    chk("req_val", {63'd0, req_val}, {63'd0, m_val});
    if (m_val) chk("req_data", req_data, m_data);
    chk("in_rdy", {63'd0, in_rdy}, {63'd0, (m_mode == 1) && (mq.size() < DEPTH)});
    chk("drained", {63'd0, drained}, {63'd0, m_mode == 3});
    chk("credit_cnt", {60'd0, credit_cnt}, 64'(m_cred));
    chk("fifo_cnt", {61'd0, fifo_cnt}, 64'(mq.size()));
    chk("err_credit_ovf", {63'd0, err_credit_ovf}, {63'd0, m_ovf});
    if (rst_n && req_val) begin
      beat_log.push_back(req_data);
      beat_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [63:0] d);
    int t;
    t       = 0;
    in_val  = 1'b1;
    in_data = d;
    while (!in_rdy && t < 60) begin
      tick();
      t++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_rdy 0 expected 1 for data 0x%0h", d);
    end
    tick();
    in_val = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    in_val     = 1'b0;
    in_data    = '0;
    req_credit = 1'b0;
    drain_req  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Startup cycle: nothing accepted yet, reset values visible.
    @(negedge clk);
    chk("rst_in_rdy", {63'd0, in_rdy}, 64'd0);
    chk("rst_credit", {60'd0, credit_cnt}, 64'd8);
    chk("rst_fifo", {61'd0, fifo_cnt}, 64'd0);
    chk("rst_req_data", req_data, 64'd0);
    chk("rst_drained", {63'd0, drained}, 64'd0);
    tick();
    beat_log.delete();
    beat_cyc.delete();

    // Three back-to-back pushes stream straight out.
    push(64'h11);
    push(64'h22);
    push(64'h33);
    repeat (4) tick();
    @(negedge clk);
    chk("t1_nbeats", 64'(beat_log.size()), 64'd3);
    chk("t1_b0", beat_log[0], 64'h11);
    chk("t1_b1", beat_log[1], 64'h22);
    chk("t1_b2", beat_log[2], 64'h33);
    chk("t1_consec", 64'(beat_cyc[2] - beat_cyc[0]), 64'd2);
    chk("t1_credit", {60'd0, credit_cnt}, 64'd5);

    // Refill credits, then push until credits and FIFO are exhausted.
    req_credit = 1'b1;
    repeat (3) tick();
    req_credit = 1'b0;
    @(negedge clk);
    chk("t2_refill", {60'd0, credit_cnt}, 64'd8);
    beat_log.delete();
    for (int i = 0; i < 12; i++) push(64'h100 + 64'(i));
    repeat (3) tick();
    @(negedge clk);
    chk("t2_nbeats", 64'(beat_log.size()), 64'd8);
    chk("t2_credit0", {60'd0, credit_cnt}, 64'd0);
    chk("t2_full", {61'd0, fifo_cnt}, 64'd4);
    chk("t2_rdy_low", {63'd0, in_rdy}, 64'd0);
    req_credit = 1'b1;
    repeat (2) tick();
    req_credit = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t2_nbeats2", 64'(beat_log.size()), 64'd10);
    chk("t2_b8", beat_log[8], 64'h108);
    chk("t2_b9", beat_log[9], 64'h109);
    chk("t2_fifo2", {61'd0, fifo_cnt}, 64'd2);
    chk("t2_rdy_high", {63'd0, in_rdy}, 64'd1);

    // Credit return in the same cycle as a send leaves the count unchanged.
    req_credit = 1'b1;
    repeat (5) tick();
    req_credit = 1'b0;
    @(negedge clk);
    chk("t3_credit3", {60'd0, credit_cnt}, 64'd3);
    chk("t3_empty", {61'd0, fifo_cnt}, 64'd0);
    push(64'h3C);
    req_credit = 1'b1;
    tick();
    req_credit = 1'b0;
    @(negedge clk);
    chk("t3_val", {63'd0, req_val}, 64'd1);
    chk("t3_data", req_data, 64'h3C);
    chk("t3_same", {60'd0, credit_cnt}, 64'd3);

    // Overflow: return at MAX with an empty FIFO.
    req_credit = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("t4_max", {60'd0, credit_cnt}, 64'd8);
    chk("t4_no_err", {63'd0, err_credit_ovf}, 64'd0);
    tick();
    req_credit = 1'b0;
    @(negedge clk);
    chk("t4_sat", {60'd0, credit_cnt}, 64'd8);
    chk("t4_err", {63'd0, err_credit_ovf}, 64'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("t4_sticky", {63'd0, err_credit_ovf}, 64'd1);

    // Drain with two entries in flight and five credits outstanding.
    beat_log.delete();
    for (int i = 0; i < 5; i++) push(64'h500 + 64'(i));
    in_val  = 1'b1;
    in_data = 64'h510;
    tick();
    in_data   = 64'h511;
    drain_req = 1'b1;
    tick();
    in_val = 1'b0;
    @(negedge clk);
    chk("t5_rdy_low", {63'd0, in_rdy}, 64'd0);
    chk("t5_fifo1", {61'd0, fifo_cnt}, 64'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_nbeats", 64'(beat_log.size()), 64'd7);
    chk("t5_b5", beat_log[5], 64'h510);
    chk("t5_b6", beat_log[6], 64'h511);
    chk("t5_credit1", {60'd0, credit_cnt}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      req_credit = 1'b1;
      tick();
      req_credit = 1'b0;
      tick();
    end
    @(negedge clk);
    chk("t5_not_yet", {63'd0, drained}, 64'd0);
    chk("t5_credit7", {60'd0, credit_cnt}, 64'd7);
    req_credit = 1'b1;
    tick();
    req_credit = 1'b0;
    @(negedge clk);
    chk("t5_not_yet2", {63'd0, drained}, 64'd0);
    tick();
    @(negedge clk);
    chk("t5_drained", {63'd0, drained}, 64'd1);
    chk("t5_drained_rdy", {63'd0, in_rdy}, 64'd0);
    drain_req = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_release", {63'd0, drained}, 64'd0);
    chk("t5_rdy_back", {63'd0, in_rdy}, 64'd1);

    // Reset in the middle of a burst with three entries queued.
    for (int i = 0; i < 11; i++) push(64'h600 + 64'(i));
    repeat (2) tick();
    @(negedge clk);
    chk("t6_fifo3", {61'd0, fifo_cnt}, 64'd3);
    chk("t6_credit0", {60'd0, credit_cnt}, 64'd0);
    req_credit = 1'b1;
    tick();
    req_credit = 1'b0;
    in_val     = 1'b1;
    in_data    = 64'h60B;
    tick();
    in_val = 1'b0;
    chk("t6_val_pre", {63'd0, req_val}, 64'd1);
    chk("t6_fifo_pre", {61'd0, fifo_cnt}, 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_val_async", {63'd0, req_val}, 64'd0);
    chk("t6_fifo_async", {61'd0, fifo_cnt}, 64'd0);
    chk("t6_credit_async", {60'd0, credit_cnt}, 64'd8);
    chk("t6_err_cleared", {63'd0, err_credit_ovf}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_init_rdy", {63'd0, in_rdy}, 64'd0);
    chk("t6_init_fifo", {61'd0, fifo_cnt}, 64'd0);
    chk("t6_init_credit", {60'd0, credit_cnt}, 64'd8);
    tick();
    @(negedge clk);
    chk("t6_run_rdy", {63'd0, in_rdy}, 64'd1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
